alu_share_arbiter: RTL and testbench

Shares one 32-bit combinational ALU between NUM_REQ requesters, e.g. the branch-compare path, address generation and a multi-cycle helper. Requests use valid/ready handshakes. Requesters are granted in round-robin order, and one transaction is in flight at a time. The result is registered and returned on a single response channel tagged with the requester id. The block sits beside the execute stage and instantiates the existing ALU as its only datapath.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu.sv | 35 +++
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, arbiter FSM states and the latched operand payload.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_AND  = 4'b0000;
  localparam alu_op_t OP_OR   = 4'b0001;
  localparam alu_op_t OP_ADD  = 4'b0010;
  localparam alu_op_t OP_XOR  = 4'b0011;
  localparam alu_op_t OP_NOR  = 4'b0100;
  localparam alu_op_t OP_SUB  = 4'b0110;
  localparam alu_op_t OP_SLT  = 4'b0111;
  localparam alu_op_t OP_SLTU = 4'b1000;
  localparam alu_op_t OP_SLL  = 4'b1001;
  localparam alu_op_t OP_SRL  = 4'b1010;
  localparam alu_op_t OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_t           op;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; shifts move b by a[4:0], undefined opcodes yield 0.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result_c
);

  localparam int unsigned SHAMT_W = 5;

  logic [SHAMT_W-1:0] shamt;

  assign shamt = a[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_NOR:  result_c = ~(a | b);
      OP_SLT:  result_c = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result_c = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLL:  result_c = b << shamt;
      OP_SRL:  result_c = b >> shamt;
      OP_SRA:  result_c = DATA_W'($signed(b) >>> shamt);
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, one transaction in
// flight, registered result returned on a single id-tagged response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  alu_req_t            opnd_q, opnd_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];
  alu_op_t             op_arr [NUM_REQ];
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  int unsigned         scan_idx;
  logic [DATA_W-1:0]   alu_result;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[DATA_W*g +: DATA_W];
    assign b_arr[g]  = req_b[DATA_W*g +: DATA_W];
    assign op_arr[g] = req_op[OP_W*g +: OP_W];
  end

  // Priority scan starting at rr_ptr and wrapping, so the last winner goes last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      scan_idx = (32'(rr_ptr_q) + j) % NUM_REQ;
      if (!gnt_found && req_valid[ID_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(scan_idx);
      end
    end
  end

  alu u_alu (
    .a        (opnd_q.a),
    .b        (opnd_q.b),
    .op       (opnd_q.op),
    .result_c (alu_result)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    opnd_d       = opnd_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready = NUM_REQ'(1) << gnt_id;
          opnd_d    = '{a: a_arr[gnt_id], b: b_arr[gnt_id], op: op_arr[gnt_id]};
          id_d      = gnt_id;
          rr_ptr_d  = ID_W'((32'(gnt_id) + 1) % NUM_REQ);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = (alu_result == '0);
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Return to IDLE only; a new grant waits for the following cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      opnd_q       <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      opnd_q       <= opnd_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic against
// a behavioural round-robin and ALU model.
module tb_alu_share_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*32-1:0] req_a, req_b;
  logic [NR*4-1:0]  req_op;
  logic          rsp_valid, rsp_ready, rsp_zero, busy;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_result;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic [31:0] ma [NR];
  logic [31:0] mb [NR];
  logic [3:0]  mop [NR];

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .busy(busy)
  );

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int sh;
    logic [31:0] r;
    sh = int'(a % 32);
    case (op)
      4'h2: return a + b;
      4'h6: return a - b;
      4'h0: return a & b;
      4'h1: return a | b;
      4'h3: return a ^ b;
      4'h4: return ~(a | b);
      4'h7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h8: return (a < b) ? 32'd1 : 32'd0;
      4'h9: return b << sh;
      4'hA: return b >> sh;
      4'hB: begin
        r = b >> sh;
        if (b[31]) for (int k = 0; k < sh; k++) r[31-k] = 1'b1;
        return r;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_grant(logic [NR-1:0] mask, int ptr);
    for (int k = 0; k < NR; k++)
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_valid[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[4*i +: 4] = op;
    ma[i] = a; mb[i] = b; mop[i] = op;
  endtask

  // Lone request from requester i; returns at the negedge after the accept edge.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [NR-1:0] rdy_seen);
    set_req(i, a, b, op);
    #1 rdy_seen = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    model_ptr = (i + 1) % NR;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_result !== 32'd0 || rsp_id !== 2'd0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_fields: got %h/%0d/%b expected 0/0/0", rsp_result, rsp_id, rsp_zero);
    end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NR-1:0] rdy;
    issue(0, 32'd5, 32'd7, 4'h2, rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", rdy); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
      errors++; $display("FAIL single_exec: got valid=%b busy=%b ready=%b expected 0/1/0000", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_rsp: got v=%b r=%h z=%b id=%0d expected 1/0000000c/0/0", rsp_valid, rsp_result, rsp_zero, rsp_id);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got v=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    bit ok;
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'(i), 32'(i), 4'h6);
    for (int n = 0; n < NR; n++) begin
      exp = model_grant(req_valid, model_ptr);
      #1;
      checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'(1 << exp)); end
      @(posedge clk); @(negedge clk);
      req_valid[exp] = 1'b0;
      model_ptr = (exp + 1) % NR;
      wait_rsp(ok);
      checks++; if (!ok || rsp_id !== 2'(exp) || rsp_result !== ref_alu(ma[exp], mb[exp], mop[exp]) || rsp_zero !== 1'b1) begin
        errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d r=%h z=%b expected 1/%0d/0/1", n, rsp_valid, rsp_id, rsp_result, rsp_zero, exp);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NR; i++) set_req(i, 32'(i), 32'(i), 4'h6);
    exp = model_grant(req_valid, model_ptr);
    #1;
    checks++; if (req_ready !== 4'(1 << exp) || exp != 0) begin errors++; $display("FAIL rr_wrap: got %b expected 0001", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    model_ptr = 1;
    wait_rsp(ok);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] rdy;
    bit ok;
    rsp_ready = 1'b0;
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'h7, rdy);
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL bp_ready: got %b expected 0010", rdy); end
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no response expected rsp_valid"); end
    set_req(2, 32'd1, 32'd1, 4'h2);
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_id !== 2'd1 || rsp_zero !== 1'b0 || req_ready !== 4'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%h id=%0d z=%b rdy=%b expected 1/00000001/1/0/0000",
                           c, rsp_valid, rsp_result, rsp_id, rsp_zero, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b expected 0/0", rsp_valid, busy); end
  endtask

  task automatic test_shifts();
    logic [31:0] ta [3] = '{32'd4, 32'd4, 32'd36};
    logic [31:0] tb [3] = '{32'h8000_0000, 32'h8000_0000, 32'd1};
    logic [3:0]  top [3] = '{4'hB, 4'hA, 4'h9};
    logic [31:0] texp [3] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0010};
    logic [NR-1:0] rdy;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      issue(k, ta[k], tb[k], top[k], rdy);
      wait_rsp(ok);
      checks++; if (!ok || rsp_result !== texp[k] || rsp_result !== ref_alu(ta[k], tb[k], top[k]) || rsp_id !== 2'(k)) begin
        errors++; $display("FAIL shift%0d: got %h id=%0d expected %h id=%0d", k, rsp_result, rsp_id, texp[k], k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_undef();
    logic [NR-1:0] rdy;
    bit ok;
    issue(3, 32'd3, 32'd3, 4'hF, rdy);
    wait_rsp(ok);
    checks++; if (!ok || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL undef_rsp: got r=%h z=%b id=%0d expected 0/1/3", rsp_result, rsp_zero, rsp_id);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL undef_idle: got busy=%b v=%b expected 0/0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] rdy;
    int exp;
    bit ok;
    issue(1, 32'd10, 32'd20, 4'h2, rdy);
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_now: got v=%b busy=%b expected 0/0", rsp_valid, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost%0d: got v=%b expected 0", c, rsp_valid); end
    end
    set_req(0, 32'd9, 32'd1, 4'h6);
    set_req(2, 32'd1, 32'd1, 4'h2);
    exp = model_grant(req_valid, model_ptr);
    #1;
    checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rstmid_grant: got %b expected %b", req_ready, 4'(1 << exp)); end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    model_ptr = (exp + 1) % NR;
    wait_rsp(ok);
    checks++; if (!ok || rsp_id !== 2'(exp) || rsp_result !== ref_alu(ma[exp], mb[exp], mop[exp])) begin
      errors++; $display("FAIL rstmid_rsp: got id=%0d r=%h expected id=%0d", rsp_id, rsp_result, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int exp, hold;
    logic [31:0] eres;
    bit ok;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (req_valid == '0) set_req(int'($urandom_range(0, NR-1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      exp = model_grant(req_valid, model_ptr);
      eres = ref_alu(ma[exp], mb[exp], mop[exp]);
      rsp_ready = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      #1;
      checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rand%0d_grant: got %b expected %b", t, req_ready, 4'(1 << exp)); end
      @(posedge clk); @(negedge clk);
      req_valid[exp] = 1'b0;
      model_ptr = (exp + 1) % NR;
      wait_rsp(ok);
      checks++; if (!ok || rsp_id !== 2'(exp) || rsp_result !== eres || rsp_zero !== (eres == 32'd0)) begin
        errors++; $display("FAIL rand%0d_rsp: got v=%b id=%0d r=%h z=%b expected id=%0d r=%h", t, rsp_valid, rsp_id, rsp_result, rsp_zero, exp, eres);
      end
      if (!rsp_ready) begin
        repeat (hold) @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== eres) begin errors++; $display("FAIL rand%0d_hold: got v=%b r=%h expected 1/%h", t, rsp_valid, rsp_result, eres); end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_done: got v=%b expected 0", t, rsp_valid); end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_shifts();
    test_undef();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
